fa_dataflow_core: RTL and testbench

- Parameterizable ripple-carry full adder; default WIDTH=1 is the classic 1-bit full adder (a + b + ci -> s, co).
- Primary sum and carry outputs are purely combinational. Tables and checks that sample after a settle delay with no clock edge depend on this.
- Also provides registered copies of sum and carry for pipelined consumers.
- Used as the leaf arithmetic cell in datapath blocks; STYLE selects one of three equivalent internal formulations.

---
 rtl/fa_dataflow_core_pkg.sv | 13 +
 rtl/fa_dataflow_core_bit.sv | 45 ++++
 rtl/fa_dataflow_core.sv | 55 +++++
 tb/tb_fa_dataflow_core.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fa_dataflow_core_pkg.sv
// Shared constants for the full-adder cell family: STYLE encodings and a legality helper.
package fa_dataflow_core_pkg;

  localparam int unsigned STYLE_DATAFLOW = 0;
  localparam int unsigned STYLE_BEHAV    = 1;
  localparam int unsigned STYLE_CASE     = 2;
  localparam int unsigned STYLE_MAX      = STYLE_CASE;

  function automatic bit style_is_legal(input int unsigned style);
    return style <= STYLE_MAX;
  endfunction

endpackage

// File: rtl/fa_dataflow_core_bit.sv
// One-bit full adder; STYLE picks one of three bit-identical formulations at elaboration.
module fa_bit
  import fa_dataflow_core_pkg::*;
#(
  parameter int unsigned STYLE = STYLE_DATAFLOW
) (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  if (STYLE == STYLE_DATAFLOW) begin : g_dataflow
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
  end else if (STYLE == STYLE_BEHAV) begin : g_behav
    logic [1:0] sum;
    assign sum = 2'(a) + 2'(b) + 2'(ci);
    assign s   = sum[0];
    assign co  = sum[1];
  end else if (STYLE == STYLE_CASE) begin : g_case
    // Unknown selectors fall through to X so bad inputs stay visible on this bit only.
    always_comb begin
      s  = 1'b0;
      co = 1'b0;
      case ({ci, a, b})
        3'b000: begin s = 1'b0; co = 1'b0; end
        3'b001: begin s = 1'b1; co = 1'b0; end
        3'b010: begin s = 1'b1; co = 1'b0; end
        3'b011: begin s = 1'b0; co = 1'b1; end
        3'b100: begin s = 1'b1; co = 1'b0; end
        3'b101: begin s = 1'b0; co = 1'b1; end
        3'b110: begin s = 1'b0; co = 1'b1; end
        3'b111: begin s = 1'b1; co = 1'b1; end
        default: begin s = 1'bx; co = 1'bx; end
      endcase
    end
  end else begin : g_illegal
    $error("fa_bit: STYLE=%0d is not a legal formulation (0..%0d)", STYLE, STYLE_MAX);
    assign s  = 1'b0;
    assign co = 1'b0;
  end

endmodule

// File: rtl/fa_dataflow_core.sv
// Ripple-carry adder of WIDTH fa_bit cells with combinational sum/carry plus a registered copy.
module fa_dataflow_core
  import fa_dataflow_core_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned STYLE = STYLE_DATAFLOW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic [WIDTH-1:0] s_q,
  output logic             co_q
);

  if (WIDTH < 1) begin : g_bad_width
    $error("fa_dataflow_core: WIDTH must be >= 1");
  end

  if (!style_is_legal(STYLE)) begin : g_bad_style
    $error("fa_dataflow_core: STYLE=%0d out of range", STYLE);
  end

  // c[i] is the carry into bit i; c[WIDTH] leaves the MSB.
  logic [WIDTH:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa_bit #(.STYLE(STYLE)) u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co = c[WIDTH];

  // Pipeline copy for downstream registered consumers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q  <= '0;
      co_q <= 1'b0;
    end else begin
      s_q  <= s;
      co_q <= co;
    end
  end

endmodule

// File: tb/tb_fa_dataflow_core.sv
// Self-checking bench for fa_dataflow_core: truth table, style equivalence, register/reset, random.
module tb_fa_dataflow_core;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst = 1'b1;

  logic       w1_a, w1_b, w1_ci;
  logic [0:0] w1_s [3];
  logic       w1_co [3];
  logic [0:0] w1_sq [3];
  logic       w1_coq [3];

  logic [3:0] w4_a, w4_b, w4_s, w4_sq;
  logic       w4_ci, w4_co, w4_coq;

  logic [7:0] w8_a, w8_b;
  logic       w8_ci;
  logic [7:0] w8_s [3];
  logic       w8_co [3];
  logic [7:0] w8_sq [3];
  logic       w8_coq [3];

  int checks = 0;
  int failures = 0;

  always begin
    #5;
    if (clk_en) clk = ~clk;
    else        clk = 1'b0;
  end

  for (genvar k = 0; k < 3; k++) begin : g_duts
    fa_dataflow_core #(.WIDTH(1), .STYLE(k)) u_w1 (
      .clk(clk), .rst(rst), .a(w1_a), .b(w1_b), .ci(w1_ci),
      .s(w1_s[k]), .co(w1_co[k]), .s_q(w1_sq[k]), .co_q(w1_coq[k])
    );
    fa_dataflow_core #(.WIDTH(8), .STYLE(k)) u_w8 (
      .clk(clk), .rst(rst), .a(w8_a), .b(w8_b), .ci(w8_ci),
      .s(w8_s[k]), .co(w8_co[k]), .s_q(w8_sq[k]), .co_q(w8_coq[k])
    );
  end

  fa_dataflow_core #(.WIDTH(4), .STYLE(0)) u_w4 (
    .clk(clk), .rst(rst), .a(w4_a), .b(w4_b), .ci(w4_ci),
    .s(w4_s), .co(w4_co), .s_q(w4_sq), .co_q(w4_coq)
  );

  task automatic test_reset();
    w1_a = 1'b1; w1_b = 1'b1; w1_ci = 1'b1;
    w4_a = '0; w4_b = '0; w4_ci = 1'b0;
    w8_a = 8'hA5; w8_b = 8'h3C; w8_ci = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({w1_coq[k], w1_sq[k]} !== 2'b00) begin
        failures++;
        $display("FAIL reset_w1 style=%0d got co_q,s_q=%b want 00", k, {w1_coq[k], w1_sq[k]});
      end
      checks++;
      if ({w8_coq[k], w8_sq[k]} !== 9'h000) begin
        failures++;
        $display("FAIL reset_w8 style=%0d got %h want 000", k, {w8_coq[k], w8_sq[k]});
      end
      checks++;
      if ({w8_co[k], w8_s[k]} !== 9'(8'hA5) + 9'(8'h3C) + 9'(1'b1)) begin
        failures++;
        $display("FAIL comb_during_reset style=%0d got %h want %h", k, {w8_co[k], w8_s[k]},
                 9'(8'hA5) + 9'(8'h3C) + 9'(1'b1));
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [2:0] v;
    logic [1:0] want;
    clk_en = 1'b0;
    #10;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {w1_ci, w1_a, w1_b} = v;
      #50;
      want = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({w1_co[k], w1_s[k]} !== want) begin
          failures++;
          $display("FAIL truth_table style=%0d cab=%b got co,s=%b want %b", k, v,
                   {w1_co[k], w1_s[k]}, want);
        end
      end
      checks++;
      if (({w1_co[0], w1_s[0]} !== {w1_co[1], w1_s[1]}) ||
          ({w1_co[0], w1_s[0]} !== {w1_co[2], w1_s[2]})) begin
        failures++;
        $display("FAIL style_equiv cab=%b got %b/%b/%b want identical", v,
                 {w1_co[0], w1_s[0]}, {w1_co[1], w1_s[1]}, {w1_co[2], w1_s[2]});
      end
    end
    {w1_ci, w1_a, w1_b} = 3'b011;
    #50;
    checks++;
    if ({w1_co[0], w1_s[0]} !== 2'b10) begin
      failures++;
      $display("FAIL tt_011 got co,s=%b want 10", {w1_co[0], w1_s[0]});
    end
    clk_en = 1'b1;
  endtask

  task automatic test_width4();
    logic [3:0] ta [3] = '{4'hF, 4'hF, 4'h5};
    logic [3:0] tb [3] = '{4'h1, 4'hF, 4'h2};
    logic       tc [3] = '{1'b0, 1'b1, 1'b0};
    logic [4:0] want [3] = '{5'h10, 5'h1F, 5'h07};
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w4_a = ta[i]; w4_b = tb[i]; w4_ci = tc[i];
      #50;
      checks++;
      if ({w4_co, w4_s} !== want[i]) begin
        failures++;
        $display("FAIL width4 case=%0d got %h want %h", i, {w4_co, w4_s}, want[i]);
      end
    end
    for (int i = 0; i < 40; i++) begin
      w4_a = 4'($urandom); w4_b = 4'($urandom); w4_ci = 1'($urandom);
      #5;
      checks++;
      if ({w4_co, w4_s} !== 5'(w4_a) + 5'(w4_b) + 5'(w4_ci)) begin
        failures++;
        $display("FAIL width4_rand a=%h b=%h ci=%b got %h want %h", w4_a, w4_b, w4_ci,
                 {w4_co, w4_s}, 5'(w4_a) + 5'(w4_b) + 5'(w4_ci));
      end
    end
    clk_en = 1'b1;
  endtask

  task automatic test_registered();
    @(negedge clk);
    {w1_ci, w1_a, w1_b} = 3'b000;
    @(posedge clk); #1;
    @(negedge clk);
    {w1_ci, w1_a, w1_b} = 3'b110;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({w1_coq[k], w1_sq[k]} !== 2'b00) begin
        failures++;
        $display("FAIL reg_before_edge style=%0d got %b want 00", k, {w1_coq[k], w1_sq[k]});
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({w1_coq[k], w1_sq[k]} !== 2'b10) begin
        failures++;
        $display("FAIL reg_after_edge style=%0d got %b want 10", k, {w1_coq[k], w1_sq[k]});
      end
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    {w1_ci, w1_a, w1_b} = 3'b111;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({w1_coq[k], w1_sq[k]} !== 2'b11) begin
        failures++;
        $display("FAIL pre_reset_capture style=%0d got %b want 11", k, {w1_coq[k], w1_sq[k]});
      end
    end
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({w1_coq[k], w1_sq[k]} !== 2'b00) begin
        failures++;
        $display("FAIL async_reset style=%0d got %b want 00", k, {w1_coq[k], w1_sq[k]});
      end
      checks++;
      if ({w1_co[k], w1_s[k]} !== 2'b11) begin
        failures++;
        $display("FAIL comb_in_reset style=%0d got %b want 11", k, {w1_co[k], w1_s[k]});
      end
    end
    repeat (2) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({w1_coq[k], w1_sq[k]} !== 2'b00) begin
          failures++;
          $display("FAIL reset_hold style=%0d got %b want 00", k, {w1_coq[k], w1_sq[k]});
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({w1_coq[0], w1_sq[0]} !== 2'b00) begin
      failures++;
      $display("FAIL release_no_edge got %b want 00", {w1_coq[0], w1_sq[0]});
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({w1_coq[k], w1_sq[k]} !== 2'b11) begin
        failures++;
        $display("FAIL first_capture style=%0d got %b want 11", k, {w1_coq[k], w1_sq[k]});
      end
    end
  endtask

  task automatic test_random8();
    logic [8:0] want;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 0) begin
        w8_a = 8'hFF; w8_b = 8'hFF; w8_ci = 1'b1;
      end else begin
        w8_a = 8'($urandom); w8_b = 8'($urandom); w8_ci = 1'($urandom);
      end
      want = 9'(w8_a) + 9'(w8_b) + 9'(w8_ci);
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({w8_co[k], w8_s[k]} !== want) begin
          failures++;
          $display("FAIL rand8_comb style=%0d a=%h b=%h ci=%b got %h want %h", k, w8_a, w8_b,
                   w8_ci, {w8_co[k], w8_s[k]}, want);
        end
      end
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({w8_coq[k], w8_sq[k]} !== want) begin
          failures++;
          $display("FAIL rand8_reg style=%0d got %h want %h", k, {w8_coq[k], w8_sq[k]}, want);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_width4();
    test_registered();
    test_reset_midop();
    test_random8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
